sprite_rom_responder: RTL

// - Responder side of the sprite-fetch read port (sdr_req/sdr_addr -> sdr_rdy/sdr_data) in the M72 sprite path.
// - Takes one 64-bit (8-byte, 16-pixel 4bpp row) read request and issues it to a 16-bit SDRAM controller port as a 4-beat burst.
// - Packs the beats and returns the 64-bit word with a single-cycle ready pulse. Sits between the sprite engine and the SDRAM arbiter on CLK_96M.

---
 rtl/sprite_rom_responder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sprite_rom_responder.sv
// rtl/sprite_rom_responder.sv - 64-bit sprite row read served as a 4-beat 16-bit SDRAM burst
// Optional single-entry hit register enabled by defining SPRITE_ROM_HIT_CACHE_EN.
module sprite_rom_responder #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK_96M,
    input  logic        RESET_N,
    input  logic        sdr_req,
    input  logic [24:0] sdr_addr,
    output logic        sdr_rdy,
    output logic [63:0] sdr_data,
    output logic        mem_req,
    output logic [24:0] mem_addr,
    input  logic        mem_ack,
    input  logic        mem_dvalid,
    input  logic [15:0] mem_dout,
    input  logic        cache_flush,
    output logic        err_timeout,
    output logic        err_overrun
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BURST, S_DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic [7:0]  timer_q, timer_d;
    logic [63:0] sdr_data_q, sdr_data_d;
    logic        mem_req_q, mem_req_d;
    logic [24:0] mem_addr_q, mem_addr_d;
    logic        err_tmo_q, err_tmo_d;
    logic        err_ovr_q, err_ovr_d;
    logic        hit;
    logic        expire;

`ifdef SPRITE_ROM_HIT_CACHE_EN
    logic        tag_valid_q, tag_valid_d;
    logic [21:0] tag_q, tag_d;
    logic [2:0]  unused_bits;
    assign unused_bits = sdr_addr[2:0];
`else
    logic [3:0]  unused_bits;
    assign unused_bits = {cache_flush, sdr_addr[2:0]};
`endif

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        timer_d    = timer_q;
        sdr_data_d = sdr_data_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        err_tmo_d  = err_tmo_q;
        err_ovr_d  = err_ovr_q;
        hit        = 1'b0;
        expire     = 1'b0;
`ifdef SPRITE_ROM_HIT_CACHE_EN
        tag_valid_d = tag_valid_q;
        tag_d       = tag_q;
        // A flush in the same cycle as a matching request must not hit
        if (cache_flush) tag_valid_d = 1'b0;
        hit = tag_valid_q && (sdr_addr[24:3] == tag_q) && !cache_flush;
`endif

        if (sdr_req && (state_q != S_IDLE)) err_ovr_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (sdr_req) begin
                    if (hit) begin
                        state_d = S_DONE;
                    end else begin
                        mem_addr_d = {sdr_addr[24:3], 3'b000};
                        mem_req_d  = 1'b1;
                        timer_d    = 8'd0;
                        beat_d     = 2'd0;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = timer_q + 8'd1;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = S_BURST;
                    if (mem_dvalid) begin
                        sdr_data_d[{beat_q, 4'b0000} +: 16] = mem_dout;
                        beat_d = beat_q + 2'd1;
                    end
                end else if (timer_q == TMO_LAST) begin
                    expire = 1'b1;
                end
            end
            S_BURST: begin
                timer_d = timer_q + 8'd1;
                if (mem_dvalid) begin
                    sdr_data_d[{beat_q, 4'b0000} +: 16] = mem_dout;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        beat_d  = 2'd0;
                        state_d = S_DONE;
`ifdef SPRITE_ROM_HIT_CACHE_EN
                        tag_valid_d = 1'b1;
                        tag_d       = mem_addr_q[24:3];
`endif
                    end
                end else if (timer_q == TMO_LAST) begin
                    expire = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort returns zero data so the requester always gets its ready pulse
        if (expire) begin
            mem_req_d  = 1'b0;
            sdr_data_d = 64'd0;
            err_tmo_d  = 1'b1;
            beat_d     = 2'd0;
            state_d    = S_DONE;
`ifdef SPRITE_ROM_HIT_CACHE_EN
            tag_valid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge CLK_96M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            beat_q     <= 2'd0;
            timer_q    <= 8'd0;
            sdr_data_q <= 64'd0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 25'd0;
            err_tmo_q  <= 1'b0;
            err_ovr_q  <= 1'b0;
`ifdef SPRITE_ROM_HIT_CACHE_EN
            tag_valid_q <= 1'b0;
            tag_q       <= 22'd0;
`endif
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            timer_q    <= timer_d;
            sdr_data_q <= sdr_data_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            err_tmo_q  <= err_tmo_d;
            err_ovr_q  <= err_ovr_d;
`ifdef SPRITE_ROM_HIT_CACHE_EN
            tag_valid_q <= tag_valid_d;
            tag_q       <= tag_d;
`endif
        end
    end

    assign sdr_rdy     = (state_q == S_DONE);
    assign sdr_data    = sdr_data_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign err_timeout = err_tmo_q;
    assign err_overrun = err_ovr_q;

endmodule
